// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, LSB first, WIDTH cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_a, fa_b, fa_p, bit_s, bit_c;

  // Full-adder bit cell: sum = a^b^c, carry = a&b | c&(a^b)
  always_comb begin
    fa_a  = a_sh_q[0];
    fa_b  = b_sh_q[0];
    fa_p  = fa_a ^ fa_b;
    bit_s = fa_p ^ c_q;
    bit_c = (fa_a & fa_b) | (c_q & fa_p);
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d    = bit_c;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {bit_s, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q here is the carry into the MSB, bit_c the carry out of it
          ovf_d   = c_q ^ bit_c;
`endif
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed cases plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  sb_t q8[$];
  sb_t q2[$];
  logic [7:0] held_sum8;
  int done8_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Pop and compare on every done pulse of the 8-bit instance
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      sb_t e;
      done8_cnt++;
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e.sum));
        check("cout8", 32'(cout8), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf8", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      sb_t e;
      if (q2.size() == 0) begin
        check("done2_unexpected", 32'(done2), 32'd0);
      end else begin
        e = q2.pop_front();
        check("sum2", 32'(sum2), 32'(e.sum));
        check("cout2", 32'(cout2), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf2", 32'(ovf2), 32'(e.ovf));
`endif
      end
    end
  end

  // Caller is #1 after an edge with the DUT idle; glitch_run drives a stray start in that RUN cycle
  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input int glitch_run, input bit glitch_done);
    sb_t e;
    logic [8:0] t;
    t = 9'(av) + 9'(bv) + 9'(cv);
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (av[7] == bv[7]) && (t[7] != av[7]);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    q8.push_back(e);
    for (int i = 1; i <= 8; i++) begin
      check("busy8_run", 32'(busy8), 32'd1);
      check("done8_run", 32'(done8), 32'd0);
      check("sum8_hold", 32'(sum8), 32'(held_sum8));
      if (i == glitch_run) begin
        start8 = 1'b1; a8 = 8'hAA; cin8 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    check("done8_pulse", 32'(done8), 32'd1);
    check("busy8_done", 32'(busy8), 32'd0);
    if (glitch_done) begin
      start8 = 1'b1; a8 = 8'hAA; cin8 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0;
    held_sum8 = e.sum;
    check("done8_after", 32'(done8), 32'd0);
    check("busy8_idle", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    check("busy8_idle2", 32'(busy8), 32'd0);
    check("sum8_idle_hold", 32'(sum8), 32'(held_sum8));
  endtask

  task automatic add2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    sb_t e;
    logic [2:0] t;
    t = 3'(av) + 3'(bv) + 3'(cv);
    e.sum  = 8'(t[1:0]);
    e.cout = t[2];
    e.ovf  = (av[1] == bv[1]) && (t[1] != av[1]);
    a2 = av; b2 = bv; cin2 = cv; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    q2.push_back(e);
    check("busy2_c1", 32'(busy2), 32'd1);
    @(posedge clk); #1;
    check("busy2_c2", 32'(busy2), 32'd1);
    check("done2_early", 32'(done2), 32'd0);
    @(posedge clk); #1;
    check("done2_lat", 32'(done2), 32'd1);
    @(posedge clk); #1;
    check("done2_after", 32'(done2), 32'd0);
  endtask

  initial begin
    int done_before;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    held_sum8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_sum2", 32'(sum2), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf8", 32'(ovf8), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    add8(8'h3C, 8'h5A, 1'b0, 0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);

    // Stray starts in RUN and DONE must not launch a second add
    done_before = done8_cnt;
    add8(8'h10, 8'h20, 1'b0, 3, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("glitch_done_cnt", 32'(done8_cnt - done_before), 32'd1);

    // Reset during RUN aborts without a done pulse
    done_before = done8_cnt;
    a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_pre", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done8_cnt - done_before), 32'd0);
    held_sum8 = 8'h00;

    add8(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    add8(8'h80, 8'h80, 1'b0, 0, 1'b0);
    add8(8'h01, 8'h01, 1'b0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      add8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0);
    end

    for (int k = 0; k < 32; k++) begin
      logic [4:0] kv;
      kv = 5'(k);
      add2(kv[1:0], kv[3:2], kv[4]);
    end

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: the add-direction counterpart of the team's half-subtractor gate-level cells.
- Accepts two WIDTH-bit operands and a carry-in on a start strobe.
- Adds one bit per clock, LSB first, using a single full-adder bit cell and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits beside the FSM exercises as the first multi-cycle arithmetic block; the sum output is held stable for downstream FSMs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (state RUN)
- done  output  1  one-cycle pulse: sum/cout valid
- sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst_n low at a rising clk edge resets the block.
- Reset values: state=IDLE; busy=0, done=0, sum=0, cout=0. All internal shift registers, the carry flop and the bit counter are 0.
- Reset mid-operation: rst_n low in any state aborts the addition. State returns to IDLE with all outputs at reset values, and no done pulse is issued.
- States: IDLE, RUN, DONE. Encoding is 2-bit; the unused code returns to IDLE on the next edge.
- IDLE:
  - start=1 at an edge: capture a and b into shift registers, carry flop <= cin, count <= 0, next state RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - bit = a_sh[0] ^ b_sh[0] ^ c.
  - c <= majority(a_sh[0], b_sh[0], c).
  - Shift a_sh and b_sh right by 1.
  - Shift bit into the MSB of the internal result shift register.
  - count <= count+1.
  - On the edge where count = WIDTH-1, after the update:
    - Transfer the result register to sum.
    - Transfer the final carry to cout.
    - Next state DONE.
- DONE: done=1 for exactly this cycle. The next edge moves unconditionally to IDLE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency: if start is accepted at edge E0, busy is high for WIDTH cycles (E0+1..E0+WIDTH) and done is high in the cycle following edge E0+WIDTH. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in RUN or DONE: ignored; the a/b/cin inputs are don't-care.
- sum/cout update only at completion. They hold the previous result throughout RUN and IDLE until the next completion.
- Counter width: clog2(WIDTH)+1 bits; no wrap-around occurs inside RUN.
- The bit cell reuses the team's xor_gate/and_gate logic equations. Instantiation is allowed; behavioural equivalent is acceptable.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0): two's-complement signed overflow.
  - ovf = carry into MSB XOR carry out of MSB, registered together with sum/cout and held identically.
- Not defined: no ovf port and no overflow logic.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, one start pulse -> busy high 8 cycles, done pulse one cycle later, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. sum must stay 8'h00 during the second RUN until completion.
- Start 0x10+0x20; assert start again with a=0xAA during RUN cycle 3 and during DONE -> second start ignored, sum=8'h30, exactly one done pulse.
- Start 0x55+0x55; drive rst_n=0 during RUN cycle 4 for one edge -> busy=0, done=0, sum=0, cout=0 next cycle, and no done pulse afterwards.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=8'h80, cout=0, ovf=1; 0x80+0x80 -> sum=8'h00, cout=1, ovf=1; 0x01+0x01 -> ovf=0.
- WIDTH=2 sweep over all 32 (a,b,cin) combinations -> {cout,sum} equals a+b+cin for every case, and done occurs exactly 2 cycles after the accepting edge.
